uart_rx: RTL and testbench

//  Serial receiver for the board UART link; downstream consumer of the uart_tx line.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encodings (aligned with uart_tx), frame sizes,
// and the baud counter width helper.
package uart_rx_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

   // Baud counter must hold CLKS_PER_BIT-1; never narrower than one bit.
   function automatic int unsigned bcnt_width(input int unsigned n);
      return (n < 2) ? 1 : int'($clog2(n));
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop. Reports byte plus flags
// with a one-cycle rx_valid. Define UART_RX_SYNC_EN to synchronize rx through two flops.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int unsigned BCNT_W = bcnt_width(CLKS_PER_BIT);
   localparam int unsigned HALF   = (CLKS_PER_BIT - 1) / 2;
   localparam logic [BCNT_W-1:0] RELOAD     = BCNT_W'(CLKS_PER_BIT - 1);
   // Detection cycle itself counts as the first half-bit cycle.
   localparam logic [BCNT_W-1:0] START_LOAD = BCNT_W'((HALF == 0) ? 0 : HALF - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );
`else
   assign rx_s = rx;
`endif

   rx_state_e                   state_q, state_d;
   logic [BCNT_W-1:0]           baud_q, baud_d;
   logic [2:0]                  bit_q, bit_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic                        par_q, par_d;
   logic [UART_DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                        rx_valid_q, rx_valid_d;
   logic                        parity_err_q, parity_err_d;
   logic                        frame_err_q, frame_err_d;
   logic                        rx_busy_q, rx_busy_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_busy_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         rx_busy_q    <= rx_busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_d        = par_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               if (HALF == 0) begin
                  state_d = ST_DATA;
                  baud_d  = RELOAD;
                  bit_d   = '0;
               end else begin
                  state_d = ST_START;
                  baud_d  = START_LOAD;
               end
            end
         end
         ST_START: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BCNT_W'(1);
            end else if (!rx_s) begin
               state_d = ST_DATA;
               baud_d  = RELOAD;
               bit_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BCNT_W'(1);
            end else begin
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               baud_d  = RELOAD;
               if (bit_q == LAST_BIT) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BCNT_W'(1);
            end else begin
               par_d   = rx_s;
               baud_d  = RELOAD;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BCNT_W'(1);
            end else begin
               // Report the frame even on errors; a low stop bit parks in BREAK.
               rx_valid_d   = 1'b1;
               rx_data_d    = shift_q;
               parity_err_d = par_q != (^shift_q);
               frame_err_d  = !rx_s;
               state_d      = rx_s ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rx_busy_d = state_d != ST_IDLE;
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int LAT1 = 11 + SYNC_LAT;   // H=0, N=1
   localparam int LAT4 = 42 + SYNC_LAT;   // H=1, N=4

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx1 = 1'b1;
   logic       rx4 = 1'b1;
   logic [7:0] rx_data1, rx_data4;
   logic       rx_valid1, rx_valid4;
   logic       perr1, perr4, ferr1, ferr4, busy1, busy4;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;

   uart_rx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset(reset), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .parity_err(perr1), .frame_err(ferr1), .rx_busy(busy1)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .reset(reset), .rx(rx4), .rx_data(rx_data4), .rx_valid(rx_valid4),
      .parity_err(perr4), .frame_err(ferr4), .rx_busy(busy4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one frame on the selected line; expectation is queued once t0 is known.
   task automatic send(input bit use4, input logic [7:0] d, input logic p, input logic stop,
                       input logic exp_pe, input logic exp_fe);
      logic [10:0] bits;
      int          n;
      exp_t        e;
      bits = {stop, p, d, 1'b0};
      n = use4 ? 4 : 1;
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) begin
               if (use4) rx4 = bits[i];
               else      rx1 = bits[i];
            end
            if (i == 0 && c == 0) begin
               e.d = d; e.pe = exp_pe; e.fe = exp_fe;
               e.cyc = cyc + (use4 ? LAT4 : LAT1);
               if (use4) q4.push_back(e);
               else      q1.push_back(e);
            end
         end
      end
   endtask

   task automatic idle1(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx1 = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rx_valid1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_data", 32'(rx_data1), 32'(e1.d));
            chk("dut1_parity_err", 32'(perr1), 32'(e1.pe));
            chk("dut1_frame_err", 32'(ferr1), 32'(e1.fe));
            chk("dut1_valid_cycle", 32'(cyc), 32'(e1.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && rx_valid4) begin
         if (q4.size() == 0) begin
            chk("dut4_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e4 = q4.pop_front();
            chk("dut4_data", 32'(rx_data4), 32'(e4.d));
            chk("dut4_parity_err", 32'(perr4), 32'(e4.pe));
            chk("dut4_frame_err", 32'(ferr4), 32'(e4.fe));
            chk("dut4_valid_cycle", 32'(cyc), 32'(e4.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rx_data", 32'(rx_data1), 32'h0);
      chk("reset_rx_valid", 32'(rx_valid1), 32'h0);
      chk("reset_flags", 32'({perr1, ferr1}), 32'h0);
      chk("reset_busy", 32'(busy1), 32'h0);
      reset = 1'b0;
      idle1(4);

      // Clean A5 as uart_tx would send it.
      send(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      idle1(15);

      // A5 with wrong parity bit.
      send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      idle1(15);

      // Stop bit low, line then held low: exactly one frame, parked in BREAK.
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk("break_busy", 32'(busy1), 32'h1);
      rx1 = 1'b1;
      repeat (SYNC_LAT + 1) @(negedge clk);
      chk("break_exit_busy", 32'(busy1), 32'h0);
      chk("break_frame_err_held", 32'(ferr1), 32'h1);
      idle1(5);

      // Start glitch on the 4 clk/bit instance: rejected at the half-bit re-check.
      @(negedge clk);
      rx4 = 1'b0;
      @(negedge clk);
      rx4 = 1'b1;
      repeat (SYNC_LAT) @(negedge clk);
      chk("glitch_busy_high", 32'(busy4), 32'h1);
      @(negedge clk);
      chk("glitch_busy_drop", 32'(busy4), 32'h0);
      repeat (10) @(negedge clk);
      send(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);

      // 00 then FF with one idle bit between them: valids 12 cycles apart.
      send(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      idle1(1);
      send(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      idle1(20);

      // Reset during D4 of an 8'h77 frame aborts it.
      @(negedge clk); rx1 = 1'b0;
      @(negedge clk); rx1 = 1'b1;
      @(negedge clk); rx1 = 1'b1;
      @(negedge clk); rx1 = 1'b1;
      @(negedge clk); rx1 = 1'b0;
      @(negedge clk); rx1 = 1'b1;
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midreset_rx_data", 32'(rx_data1), 32'h0);
      chk("midreset_valid", 32'(rx_valid1), 32'h0);
      chk("midreset_flags", 32'({perr1, ferr1}), 32'h0);
      chk("midreset_busy", 32'(busy1), 32'h0);
      rx1 = 1'b1;
      reset = 1'b0;
      idle1(4);
      send(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      idle1(30);

      chk("dut1_queue_drained", 32'(q1.size()), 32'h0);
      chk("dut4_queue_drained", 32'(q4.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
